// File: rtl/i2s_pkg.sv
// Shared constants and state type for the I2S transmitter.
//   SLOT_W      - bits per channel slot on the wire
//   FRAME_SLOTS - BCLK periods per LRCLK frame (left + right)
//   BCLK_HALF   - master_clk cycles per BCLK half period
package i2s_pkg;

  localparam int unsigned SLOT_W      = 16;
  localparam int unsigned FRAME_SLOTS = 32;
  localparam int unsigned BCLK_HALF   = 8;

  typedef enum logic {
    StIdle,
    StRun
  } i2s_state_e;

endpackage

// File: rtl/i2s_bclk_gen.sv
// BCLK generator: the bit tick forces BCLK low and restarts the half-period
// counter; BCLK goes high BCLK_HALF master cycles later and stays high until
// the next tick.
//   clk_i  - master clock
//   rst_i  - asynchronous active-high reset
//   run_i  - transmitter running (counter frozen while idle)
//   tick_i - bit tick, one cycle wide
//   bclk_o - bit clock
module i2s_bclk_gen
  import i2s_pkg::*;
(
  input  logic clk_i,
  input  logic rst_i,
  input  logic run_i,
  input  logic tick_i,
  output logic bclk_o
);

  localparam int unsigned CntW = $clog2(BCLK_HALF + 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            bclk_q, bclk_d;

  always_comb begin
    cnt_d  = cnt_q;
    bclk_d = bclk_q;
    if (tick_i) begin
      cnt_d  = '0;
      bclk_d = 1'b0;
    end else if (run_i) begin
      // Saturate so a missing strobe leaves BCLK parked high.
      if (cnt_q != CntW'(BCLK_HALF)) begin
        cnt_d = cnt_q + CntW'(1);
      end
      if (cnt_q == CntW'(BCLK_HALF - 1)) begin
        bclk_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q  <= '0;
      bclk_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      bclk_q <= bclk_d;
    end
  end

  assign bclk_o = bclk_q;

endmodule

// File: rtl/i2s_tx.sv
// Stereo Philips I2S transmitter. Accepts one sample pair per frame over a
// valid/ready handshake into a holding register, moves it into the frame
// register at each sample_clk_en, and shifts it out MSB first with a
// one-BCLK data delay after each LRCLK edge.
//   master_clk, rst              - clock, asynchronous active-high reset
//   sample_clk_en, bit_clk_en    - frame-start and bit strobes from the divider
//   left_sample, right_sample    - two's complement samples, SAMPLE_W bits
//   sample_valid, sample_ready   - input handshake
//   i2s_bclk, i2s_lrclk, i2s_sdata - DAC pins
//   underflow                    - pulse when a frame starts with no sample held
// Build option: define I2S_TX_UNDERFLOW_CNT_EN to add underflow_cnt[7:0], a
// saturating count of underflow pulses.
module i2s_tx
  import i2s_pkg::*;
#(
  parameter int unsigned SAMPLE_W = 16
) (
  input  logic                master_clk,
  input  logic                rst,
  input  logic                sample_clk_en,
  input  logic                bit_clk_en,
  input  logic [SAMPLE_W-1:0] left_sample,
  input  logic [SAMPLE_W-1:0] right_sample,
  input  logic                sample_valid,
  output logic                sample_ready,
  output logic                i2s_bclk,
  output logic                i2s_lrclk,
  output logic                i2s_sdata,
`ifdef I2S_TX_UNDERFLOW_CNT_EN
  output logic [7:0]          underflow_cnt,
`endif
  output logic                underflow
);

  localparam int unsigned PadW   = SLOT_W - SAMPLE_W;
  localparam int unsigned FrameW = FRAME_SLOTS;
  localparam int unsigned SlotCntW = $clog2(FRAME_SLOTS);

  i2s_state_e state_q, state_d;

  logic [FrameW-1:0]   hold_q, hold_d;
  logic                hold_full_q, hold_full_d;
  logic [FrameW-1:0]   frame_q, frame_d;
  logic                delay_q, delay_d;
  logic [SlotCntW-1:0] n_q, n_d;
  logic                lrclk_q, lrclk_d;
  logic                sdata_q, sdata_d;
  logic                underflow_q, underflow_d;

  logic                run;
  logic                tick;
  logic                xfer;
  logic [SLOT_W-1:0]   left_pad, right_pad;
  logic [FrameW-1:0]   frame_cur;
  logic [SlotCntW-1:0] n_cur;

  // MSB-align each sample in its slot, zero-filled below.
  assign left_pad  = SLOT_W'(left_sample) << PadW;
  assign right_pad = SLOT_W'(right_sample) << PadW;

  // State register.
  always_ff @(posedge master_clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: RUN is sticky until reset.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (sample_clk_en) state_d = StRun;
      StRun:  state_d = StRun;
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs: in IDLE only the frame strobe can start the bit stream.
  always_comb begin
    run  = (state_q == StRun);
    tick = sample_clk_en | (run & bit_clk_en);
  end

  // Datapath next state.
  always_comb begin
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    frame_d     = frame_q;
    delay_d     = delay_q;
    n_d         = n_q;
    lrclk_d     = lrclk_q;
    sdata_d     = sdata_q;

    xfer        = sample_valid & ~hold_full_q;
    underflow_d = sample_clk_en & ~hold_full_q;

    // The frame loaded at a frame start is already visible to slot 0 so the
    // left MSB lands in the delay bit on that same tick.
    frame_cur = sample_clk_en ? (hold_full_q ? hold_q : '0) : frame_q;
    n_cur     = sample_clk_en ? '0 : n_q + SlotCntW'(1);

    if (sample_clk_en) begin
      frame_d = frame_cur;
    end

    // xfer implies the holding register was empty, so it never races a move.
    if (xfer) begin
      hold_d      = {left_pad, right_pad};
      hold_full_d = 1'b1;
    end else if (sample_clk_en && hold_full_q) begin
      hold_d      = '0;
      hold_full_d = 1'b0;
    end

    if (tick) begin
      n_d     = n_cur;
      lrclk_d = n_cur[SlotCntW-1];
      sdata_d = delay_q;
      delay_d = frame_cur[~n_cur];  // ~n == 31 - n
    end
  end

  always_ff @(posedge master_clk or posedge rst) begin
    if (rst) begin
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      frame_q     <= '0;
      delay_q     <= 1'b0;
      n_q         <= '0;
      lrclk_q     <= 1'b0;
      sdata_q     <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      frame_q     <= frame_d;
      delay_q     <= delay_d;
      n_q         <= n_d;
      lrclk_q     <= lrclk_d;
      sdata_q     <= sdata_d;
      underflow_q <= underflow_d;
    end
  end

  i2s_bclk_gen u_bclk_gen (
    .clk_i  (master_clk),
    .rst_i  (rst),
    .run_i  (run),
    .tick_i (tick),
    .bclk_o (i2s_bclk)
  );

`ifdef I2S_TX_UNDERFLOW_CNT_EN
  logic [7:0] uf_cnt_q, uf_cnt_d;

  always_comb begin
    uf_cnt_d = uf_cnt_q;
    if (underflow_d && (uf_cnt_q != 8'hFF)) begin
      uf_cnt_d = uf_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge master_clk or posedge rst) begin
    if (rst) begin
      uf_cnt_q <= '0;
    end else begin
      uf_cnt_q <= uf_cnt_d;
    end
  end

  assign underflow_cnt = uf_cnt_q;
`endif

  assign sample_ready = ~hold_full_q;
  assign i2s_lrclk    = lrclk_q;
  assign i2s_sdata    = sdata_q;
  assign underflow    = underflow_q;

endmodule

// File: tb/tb_i2s_tx.sv
// Bench for i2s_tx: a 16-bit and a 12-bit instance share strobes and handshake.
// Expected frames are queued at each frame start and compared once the
// receiver has collected all 32 bits at the BCLK rising edges.
module tb_i2s_tx;

  logic        master_clk = 1'b0;
  logic        rst = 1'b1;
  logic        sample_clk_en = 1'b0;
  logic        bit_clk_en = 1'b0;
  logic        sample_valid = 1'b0;
  logic [15:0] left_sample = '0;
  logic [15:0] right_sample = '0;

  logic sample_ready, i2s_bclk, i2s_lrclk, i2s_sdata, underflow;
  logic ready12, bclk12, lrclk12, sdata12, underflow12;
`ifdef I2S_TX_UNDERFLOW_CNT_EN
  logic [7:0] underflow_cnt, underflow_cnt12;
`endif

  i2s_tx #(.SAMPLE_W(16)) dut (
    .master_clk    (master_clk),
    .rst           (rst),
    .sample_clk_en (sample_clk_en),
    .bit_clk_en    (bit_clk_en),
    .left_sample   (left_sample),
    .right_sample  (right_sample),
    .sample_valid  (sample_valid),
    .sample_ready  (sample_ready),
    .i2s_bclk      (i2s_bclk),
    .i2s_lrclk     (i2s_lrclk),
    .i2s_sdata     (i2s_sdata),
`ifdef I2S_TX_UNDERFLOW_CNT_EN
    .underflow_cnt (underflow_cnt),
`endif
    .underflow     (underflow)
  );

  i2s_tx #(.SAMPLE_W(12)) dut12 (
    .master_clk    (master_clk),
    .rst           (rst),
    .sample_clk_en (sample_clk_en),
    .bit_clk_en    (bit_clk_en),
    .left_sample   (left_sample[15:4]),
    .right_sample  (right_sample[15:4]),
    .sample_valid  (sample_valid),
    .sample_ready  (ready12),
    .i2s_bclk      (bclk12),
    .i2s_lrclk     (lrclk12),
    .i2s_sdata     (sdata12),
`ifdef I2S_TX_UNDERFLOW_CNT_EN
    .underflow_cnt (underflow_cnt12),
`endif
    .underflow     (underflow12)
  );

  always #5 master_clk = ~master_clk;

  int n_checks = 0;
  int n_fail = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Divider and model state.
  bit          div_on = 0;
  bit          frame_on = 0;
  int          div_cnt = 0;
  bit          m_run = 0;
  bit          m_full = 0;
  logic [31:0] m_hold = '0;
  int          m_slot = 0;
  int          m_since = 0;
  int          m_uf_cnt = 0;
  bit          want_send = 0;
  logic [15:0] send_l = '0;
  logic [15:0] send_r = '0;
  bit          last_fs = 0;

  logic [31:0] sb_q[$];
  logic [31:0] sb12_q[$];
  logic [31:0] rx = '0;
  logic [31:0] rx12 = '0;
  int          rx_bits = 0;

  task automatic send(input logic [15:0] l, input logic [15:0] r);
    send_l    = l;
    send_r    = r;
    want_send = 1;
  endtask

  // One master cycle: drive inputs, predict, clock, then check.
  task automatic step();
    bit fs, tk, xfer, exp_uf, exp_bclk;
    logic [31:0] exp_f;
    sample_clk_en = div_on && frame_on && (div_cnt % 512 == 0);
    bit_clk_en    = div_on && (div_cnt % 16 == 0);
    sample_valid  = want_send;
    left_sample   = send_l;
    right_sample  = send_r;

    fs     = sample_clk_en;
    tk     = fs || (m_run && bit_clk_en);
    xfer   = want_send && !m_full;
    exp_uf = fs && !m_full;
    if (fs) begin
      exp_f = m_full ? m_hold : 32'h0;
      sb_q.push_back(exp_f);
      sb12_q.push_back(exp_f & 32'hFFF0_FFF0);
    end

    @(posedge master_clk);
    #1;

    if (fs) begin
      m_full = 0;
      m_run  = 1;
    end
    if (xfer) begin
      m_full    = 1;
      m_hold    = {send_l, send_r};
      want_send = 0;
    end
    if (exp_uf && m_uf_cnt < 255) m_uf_cnt++;
    if (tk) begin
      m_slot  = fs ? 0 : (m_slot + 1) % 32;
      m_since = 0;
    end else if (m_run && m_since < 1000) begin
      m_since++;
    end
    if (div_on) div_cnt++;
    last_fs = fs;

    check_val("ready", sample_ready, !m_full);
    check_val("ready12", ready12, !m_full);
    check_val("underflow", underflow, exp_uf);
    check_val("underflow12", underflow12, exp_uf);
`ifdef I2S_TX_UNDERFLOW_CNT_EN
    check_val("uf_cnt", underflow_cnt, m_uf_cnt);
    check_val("uf_cnt12", underflow_cnt12, m_uf_cnt);
`endif
    exp_bclk = m_run && (m_since >= 8);
    check_val("bclk", i2s_bclk, exp_bclk);
    check_val("bclk12", bclk12, exp_bclk);
    if (!m_run) begin
      check_val("idle_lrclk", i2s_lrclk, 0);
      check_val("idle_sdata", i2s_sdata, 0);
    end

    // Receiver: sample at the BCLK rising edge.
    if (m_run && m_since == 8) begin
      check_val("lrclk", i2s_lrclk, m_slot >= 16);
      check_val("lrclk12", lrclk12, m_slot >= 16);
      if (m_slot != 0) begin
        if (m_slot == 1) rx_bits = 0;
        rx[32 - m_slot]   = i2s_sdata;
        rx12[32 - m_slot] = sdata12;
        rx_bits++;
      end else if (rx_bits == 31) begin
        rx[0]   = i2s_sdata;
        rx12[0] = sdata12;
        rx_bits = 0;
        check_val("sb_nonempty", 32'(sb_q.size() != 0), 1);
        if (sb_q.size() != 0) check_val("frame", rx, sb_q.pop_front());
        if (sb12_q.size() != 0) check_val("frame12", rx12, sb12_q.pop_front());
      end
    end
  endtask

  task automatic run_frames(input int n);
    int seen = 0;
    while (seen < n) begin
      step();
      if (last_fs) seen++;
    end
    repeat (20) step();
  endtask

  task automatic wait_frame_boundary();
    while (div_cnt % 512 != 0) step();
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_ready"}, sample_ready, 1);
    check_val({tag, "_bclk"}, i2s_bclk, 0);
    check_val({tag, "_lrclk"}, i2s_lrclk, 0);
    check_val({tag, "_sdata"}, i2s_sdata, 0);
    check_val({tag, "_underflow"}, underflow, 0);
    check_val({tag, "_ready12"}, ready12, 1);
    check_val({tag, "_bclk12"}, bclk12, 0);
    check_val({tag, "_sdata12"}, sdata12, 0);
`ifdef I2S_TX_UNDERFLOW_CNT_EN
    check_val({tag, "_uf_cnt"}, underflow_cnt, 0);
`endif
  endtask

  initial begin
    #2;
    check_reset_outputs("rst");
    @(posedge master_clk);
    #1;
    rst = 1'b0;

    // Idle with no strobes: outputs must stay at reset values.
    repeat (600) step();

    // First frame: pair presented before the divider starts.
    send(16'hA5F0, 16'h0F0F);
    repeat (5) step();
    div_on   = 1;
    frame_on = 1;
    div_cnt  = 0;
    run_frames(2);
`ifdef I2S_TX_UNDERFLOW_CNT_EN
    check_val("uf_cnt_one", underflow_cnt, 1);
`endif

    // Sample offered exactly on the frame-start cycle with the holder empty.
    wait_frame_boundary();
    send(16'h3C69, 16'h8001);
    step();
    run_frames(2);

    // 12-bit instance: 12'h801 must appear as 16'h8010 in the left slot.
    send(16'h8010, 16'h1234);
    run_frames(2);
    check_val("sb_level", 32'(sb_q.size()), 1);

    // Mid-frame reset with a sample held.
    send(16'h1111, 16'h2222);
    step();
    while (m_slot != 20) step();
    rst = 1'b1;
    #1;
    check_reset_outputs("midrst");
    @(posedge master_clk);
    #1;
    rst       = 1'b0;
    m_run     = 0;
    m_full    = 0;
    want_send = 0;
    m_slot    = 0;
    m_since   = 0;
    m_uf_cnt  = 0;
    rx_bits   = 0;
    sb_q.delete();
    sb12_q.delete();

    // Bit strobes alone must not start BCLK.
    frame_on = 0;
    div_cnt  = 0;
    repeat (200) step();
    frame_on = 1;
    wait_frame_boundary();
    run_frames(2);
    check_val("sb_level_end", 32'(sb_q.size()), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
